// File: rtl/clock_hand_evictor_if.sv
// Request/victim handshake between the CLOCK evictor and its requester.
// The requester side uses the master modport, the evictor uses slave.
interface clock_hand_evictor_if #(
    parameter int unsigned L2_DEPTH = 8
);
    logic                req_valid;
    logic                req_ready;
    logic                evict_valid;
    logic                evict_ready;
    logic [L2_DEPTH-1:0] evict_addr;
    logic                evict_forced;

    modport master (
        output req_valid,
        output evict_ready,
        input  req_ready,
        input  evict_valid,
        input  evict_addr,
        input  evict_forced
    );

    modport slave (
        input  req_valid,
        input  evict_ready,
        output req_ready,
        output evict_valid,
        output evict_addr,
        output evict_forced
    );
endinterface

// File: rtl/clock_hand_evictor.sv
// CLOCK (second-chance) victim selector: sweeps a hand over the reference-bit
// BRAM port 1, one read at a time, and returns the first index that reads 0.
module clock_hand_evictor #(
    parameter int unsigned L2_DEPTH   = 8,
    parameter int unsigned MAX_PROBES = (1 << L2_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    clock_hand_evictor_if.slave bus,
    output logic [L2_DEPTH-1:0] hand_pos,
    output logic                bram_en,
    output logic                bram_we,
    output logic [L2_DEPTH-1:0] bram_addr,
    output logic                bram_din,
    output logic                bram_rst,
    output logic                bram_regce,
    input  logic                bram_dout
);
    localparam int unsigned PCNT_W = $clog2(MAX_PROBES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PCNT_W-1:0]   probe_cnt;
    logic [PCNT_W-1:0]   probe_cnt_next;
    logic [L2_DEPTH-1:0] hand_next;
    logic [L2_DEPTH-1:0] evict_addr_next;
    logic                evict_forced_next;
    logic                last_probe_c;

    assign bram_we    = 1'b0;
    assign bram_din   = 1'b0;
    assign bram_regce = 1'b1;
    assign bram_rst   = rst;
    assign bram_addr  = hand_pos;

    assign last_probe_c = (probe_cnt + PCNT_W'(1)) == PCNT_W'(MAX_PROBES);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid && bus.req_ready) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = CHECK;
            CHECK:   state_next = (!bram_dout || last_probe_c) ? RESP : ISSUE;
            RESP:    if (bus.evict_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values; bram_dout in CHECK is the bit for the address issued two cycles earlier
    always_comb begin
        hand_next         = hand_pos;
        probe_cnt_next    = probe_cnt;
        evict_addr_next   = bus.evict_addr;
        evict_forced_next = bus.evict_forced;
        case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) probe_cnt_next = '0;
            end
            CHECK: begin
                hand_next = hand_pos + L2_DEPTH'(1);
                if (!bram_dout || last_probe_c) begin
                    evict_addr_next   = hand_pos;
                    evict_forced_next = bram_dout;
                end else begin
                    probe_cnt_next = probe_cnt + PCNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            hand_pos         <= '0;
            probe_cnt        <= '0;
            bus.req_ready    <= 1'b1;
            bus.evict_valid  <= 1'b0;
            bus.evict_addr   <= '0;
            bus.evict_forced <= 1'b0;
            bram_en          <= 1'b0;
        end else begin
            hand_pos         <= hand_next;
            probe_cnt        <= probe_cnt_next;
            bus.req_ready    <= (state_next == IDLE);
            bus.evict_valid  <= (state_next == RESP);
            bus.evict_addr   <= evict_addr_next;
            bus.evict_forced <= evict_forced_next;
            bram_en          <= (state_next == ISSUE);
        end
    end
endmodule

// File: tb/tb_clock_hand_evictor.sv
// Directed bench for clock_hand_evictor with a behavioural clear-on-read
// reference-bit BRAM (2-cycle latency) behind each instance.
module tb_clock_hand_evictor;
    localparam int unsigned L2_DEPTH = 8;
    localparam int unsigned DEPTH    = 1 << L2_DEPTH;
    localparam int          TIMEOUT  = 2000;

    logic clk;
    logic rst;

    clock_hand_evictor_if #(.L2_DEPTH(L2_DEPTH)) evict_if ();
    clock_hand_evictor_if #(.L2_DEPTH(L2_DEPTH)) evict4_if ();

    logic [L2_DEPTH-1:0] hand_pos, bram_addr;
    logic                bram_en, bram_we, bram_din, bram_rst, bram_regce, bram_dout;
    logic [L2_DEPTH-1:0] hand_pos4, bram_addr4;
    logic                bram_en4, bram_we4, bram_din4, bram_rst4, bram_regce4, bram_dout4;

    logic bits0 [DEPTH];
    logic bits4 [DEPTH];
    logic q1_0, q1_4;

    int n_tests = 0;
    int n_fail  = 0;

    clock_hand_evictor #(.L2_DEPTH(L2_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(evict_if.slave),
        .hand_pos(hand_pos), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_rst(bram_rst),
        .bram_regce(bram_regce), .bram_dout(bram_dout)
    );

    clock_hand_evictor #(.L2_DEPTH(L2_DEPTH), .MAX_PROBES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(evict4_if.slave),
        .hand_pos(hand_pos4), .bram_en(bram_en4), .bram_we(bram_we4),
        .bram_addr(bram_addr4), .bram_din(bram_din4), .bram_rst(bram_rst4),
        .bram_regce(bram_regce4), .bram_dout(bram_dout4)
    );

    always #5 clk = ~clk;

    // Port 1 of each BRAM: read clears the bit, data appears after the output register
    always @(posedge clk) begin
        if (bram_en) begin
            q1_0 <= bits0[bram_addr];
            bits0[bram_addr] <= 1'b0;
        end
        if (bram_rst) bram_dout <= 1'b0;
        else if (bram_regce) bram_dout <= q1_0;
        if (bram_en4) begin
            q1_4 <= bits4[bram_addr4];
            bits4[bram_addr4] <= 1'b0;
        end
        if (bram_rst4) bram_dout4 <= 1'b0;
        else if (bram_regce4) bram_dout4 <= q1_4;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill0(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi; i++) bits0[i] = v;
    endtask

    // Accept a request on the main instance and wait for the victim; returns cycles since accept
    task automatic start_req(output int cyc);
        evict_if.req_valid = 1'b1;
        @(posedge clk); #1;
        evict_if.req_valid = 1'b0;
        cyc = 1;
        while (!evict_if.evict_valid && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!evict_if.evict_valid) check_eq("evict_valid_timeout", 32'(evict_if.evict_valid), 32'd1);
    endtask

    task automatic finish_req();
        evict_if.evict_ready = 1'b1;
        @(posedge clk); #1;
        evict_if.evict_ready = 1'b0;
        check_eq("req_ready_after_accept", 32'(evict_if.req_ready), 32'd1);
    endtask

    initial begin
        int  cyc;
        logic stable_ok, rr_ok, en_ok;
        logic [L2_DEPTH-1:0] held_addr;
        logic held_forced;

        clk = 1'b0;
        rst = 1'b1;
        evict_if.req_valid   = 1'b0;
        evict_if.evict_ready = 1'b0;
        evict4_if.req_valid   = 1'b0;
        evict4_if.evict_ready = 1'b0;
        q1_0 = 1'b0;
        q1_4 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bits0[i] = 1'b0;
            bits4[i] = 1'b0;
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_bram_rst", 32'(bram_rst), 32'd1);
        check_eq("rst_req_ready", 32'(evict_if.req_ready), 32'd1);
        check_eq("rst_evict_valid", 32'(evict_if.evict_valid), 32'd0);
        check_eq("rst_evict_addr", 32'(evict_if.evict_addr), 32'd0);
        check_eq("rst_evict_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("rst_hand_pos", 32'(hand_pos), 32'd0);
        check_eq("rst_bram_en", 32'(bram_en), 32'd0);
        check_eq("rst_bram_we", 32'(bram_we), 32'd0);
        check_eq("rst_bram_din", 32'(bram_din), 32'd0);
        check_eq("rst_bram_regce", 32'(bram_regce), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("bram_rst_low", 32'(bram_rst), 32'd0);

        // 1: first entry clear
        start_req(cyc);
        check_eq("t1_latency", 32'(cyc), 32'd4);
        check_eq("t1_addr", 32'(evict_if.evict_addr), 32'd0);
        check_eq("t1_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("t1_hand", 32'(hand_pos), 32'd1);
        finish_req();

        // 2: second chance from hand 0
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        fill0(0, 2, 1'b1);
        start_req(cyc);
        check_eq("t2_latency", 32'(cyc), 32'd13);
        check_eq("t2_addr", 32'(evict_if.evict_addr), 32'd3);
        check_eq("t2_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("t2_bits_cleared", 32'({bits0[0], bits0[1], bits0[2]}), 32'd0);
        finish_req();
        start_req(cyc);
        check_eq("t2_next_addr", 32'(evict_if.evict_addr), 32'd4);
        check_eq("t2_next_latency", 32'(cyc), 32'd4);
        finish_req();

        // 3: wrap; first walk the hand to 254
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        fill0(0, 252, 1'b1);
        start_req(cyc);
        check_eq("t3_pre_addr", 32'(evict_if.evict_addr), 32'd253);
        finish_req();
        check_eq("t3_hand_254", 32'(hand_pos), 32'd254);
        fill0(254, 255, 1'b1);
        start_req(cyc);
        check_eq("t3_latency", 32'(cyc), 32'd10);
        check_eq("t3_addr", 32'(evict_if.evict_addr), 32'd0);
        check_eq("t3_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("t3_hand", 32'(hand_pos), 32'd1);
        finish_req();

        // 4a: all set, default probe limit lets index 0 be re-read clear
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        fill0(0, int'(DEPTH) - 1, 1'b1);
        start_req(cyc);
        check_eq("t4_latency", 32'(cyc), 32'd772);
        check_eq("t4_addr", 32'(evict_if.evict_addr), 32'd0);
        check_eq("t4_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("t4_hand", 32'(hand_pos), 32'd1);
        finish_req();

        // 4b: all set, probe limit 4 forces index 3
        for (int i = 0; i < int'(DEPTH); i++) bits4[i] = 1'b1;
        evict4_if.req_valid = 1'b1;
        @(posedge clk); #1;
        evict4_if.req_valid = 1'b0;
        cyc = 1;
        while (!evict4_if.evict_valid && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("t4f_latency", 32'(cyc), 32'd13);
        check_eq("t4f_addr", 32'(evict4_if.evict_addr), 32'd3);
        check_eq("t4f_forced", 32'(evict4_if.evict_forced), 32'd1);
        check_eq("t4f_hand", 32'(hand_pos4), 32'd4);
        check_eq("t4f_bit4_untouched", 32'(bits4[4]), 32'd1);
        evict4_if.evict_ready = 1'b1;
        @(posedge clk); #1;
        evict4_if.evict_ready = 1'b0;
        check_eq("t4f_req_ready", 32'(evict4_if.req_ready), 32'd1);

        // 5: backpressure; hand is 1 and every bit is clear
        start_req(cyc);
        check_eq("t5_latency", 32'(cyc), 32'd4);
        check_eq("t5_addr", 32'(evict_if.evict_addr), 32'd1);
        held_addr   = evict_if.evict_addr;
        held_forced = evict_if.evict_forced;
        stable_ok = 1'b1;
        rr_ok     = 1'b1;
        en_ok     = 1'b1;
        evict_if.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!evict_if.evict_valid || evict_if.evict_addr != held_addr ||
                evict_if.evict_forced != held_forced) stable_ok = 1'b0;
            if (evict_if.req_ready) rr_ok = 1'b0;
            if (bram_en) en_ok = 1'b0;
        end
        evict_if.req_valid = 1'b0;
        check_eq("t5_victim_stable", 32'(stable_ok), 32'd1);
        check_eq("t5_req_ready_low", 32'(rr_ok), 32'd1);
        check_eq("t5_no_bram_en", 32'(en_ok), 32'd1);
        finish_req();

        // 6: reset during WAIT
        fill0(0, int'(DEPTH) - 1, 1'b1);
        evict_if.req_valid = 1'b1;
        @(posedge clk); #1;
        evict_if.req_valid = 1'b0;
        check_eq("t6_issue_en", 32'(bram_en), 32'd1);
        @(posedge clk); #1;
        check_eq("t6_wait_en", 32'(bram_en), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t6_hand", 32'(hand_pos), 32'd0);
        check_eq("t6_evict_valid", 32'(evict_if.evict_valid), 32'd0);
        check_eq("t6_req_ready", 32'(evict_if.req_ready), 32'd1);
        check_eq("t6_bram_en", 32'(bram_en), 32'd0);
        fill0(0, int'(DEPTH) - 1, 1'b0);
        start_req(cyc);
        check_eq("t6_latency", 32'(cyc), 32'd4);
        check_eq("t6_addr", 32'(evict_if.evict_addr), 32'd0);
        check_eq("t6_forced", 32'(evict_if.evict_forced), 32'd0);
        check_eq("t6_hand_after", 32'(hand_pos), 32'd1);
        finish_req();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_hand_evictor.md
# clock_hand_evictor

- CLOCK (second-chance) replacement controller for the memcached key/value store.
- Sits directly upstream of the dual-port register-with-reference-bit BRAM and drives its 1-bit port 1.
- On an eviction request, it sweeps a hand across the table. It reads each entry's reference bit; the BRAM clears the bit as a side effect of the read. It returns the first index whose bit reads 0.
- Port 2, driven by the lookup path, sets bits on hits. This block never touches port 2.

## Interface

Parameters:
- L2_DEPTH, 8, log2 of table depth; must match the BRAM.
- MAX_PROBES, 2**L2_DEPTH + 1, probe limit per request before a forced eviction.

Clocking: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  single clock; shared with the BRAM.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  eviction request.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- evict_valid  out  1  victim available.
- evict_ready  in  1  consumer accepts the victim.
- evict_addr  out  L2_DEPTH  victim index.
- evict_forced  out  1  victim chosen because the probe limit was hit, not because a clear bit was found.
- hand_pos  out  L2_DEPTH  current hand position (debug/stats).
- bram_en  out  1  BRAM port 1 enable.
- bram_we  out  1  BRAM port 1 write enable; tied to 0.
- bram_addr  out  L2_DEPTH  BRAM port 1 address; equals hand_pos.
- bram_din  out  1  BRAM port 1 write data; tied to 0.
- bram_rst  out  1  BRAM port 1 output-register reset; equals rst.
- bram_regce  out  1  BRAM port 1 output-register enable; tied to 1.
- bram_dout  in  1  reference bit; 2-cycle read latency.

## Operation

States: IDLE, ISSUE, WAIT, CHECK, RESP.

- **IDLE:** req_ready=1.
  - On handshake: probe_cnt<=0, go to ISSUE.
- **ISSUE:** bram_en=1 for exactly one cycle, bram_addr=hand. Go to WAIT.
- **WAIT:** bram_en=0. Go to CHECK.
- **CHECK:** sample bram_dout. This is the bit for the address issued two cycles earlier.
  - Bit 0: evict_addr<=hand, evict_forced<=0, hand<=hand+1, go to RESP.
  - Bit 1, and probe_cnt+1 == MAX_PROBES: evict_addr<=hand, evict_forced<=1, hand<=hand+1, go to RESP.
  - Bit 1 otherwise: hand<=hand+1, probe_cnt<=probe_cnt+1, go to ISSUE.
- **RESP:** evict_valid=1, holding evict_addr and evict_forced stable.
  - On evict_ready: go to IDLE.

Rules:
- At most one read is outstanding at any time. No speculative reads are issued, so no bit beyond the victim is cleared.
- hand is L2_DEPTH bits and wraps modulo 2**L2_DEPTH (e.g. 255+1 -> 0).
- probe_cnt is wide enough to hold MAX_PROBES.
- bram_en is asserted only in ISSUE. The block never writes.
- Port-2 sets racing a probe are not arbitrated; the BRAM's behaviour governs.
- The victim's own bit is left cleared; the lookup path re-sets it on the next hit.
- A new request cannot be accepted while evict_valid is high.

## Timing

Reset values:
- state=IDLE, hand_pos=0, probe_cnt=0.
- req_ready=1, evict_valid=0, evict_addr=0, evict_forced=0.
- bram_en=0, bram_we=0, bram_din=0, bram_regce=1.
- bram_rst follows rst combinationally.

Latency:
- One probe takes 3 cycles (ISSUE, WAIT, CHECK).
- Handshake at cycle T -> ISSUE at T+1 -> evict_valid first high at T+1+3N, where N is the number of probes (1..MAX_PROBES).
- After evict_ready, req_ready is high the next cycle.

Reset mid-operation:
- Returns to IDLE next cycle and drops evict_valid.
- The hand returns to 0.
- Any in-flight BRAM read is ignored.

## Test plan

1. **First entry clear:** all bits 0, hand=0, request -> evict_addr=0, forced=0, evict_valid 4 cycles after accept; hand_pos=1.
2. **Second chance:** bits 0..2 set via port 2, request -> evict_addr=3 after 4 probes (13 cycles); BRAM bits 0..2 now read 0; next request -> evict_addr=4.
3. **Wrap:** hand at 254, bits 254 and 255 set -> evict_addr=0; hand_pos=1.
4. **All set:** all 256 bits set, MAX_PROBES=257 -> 256 clearing probes then index 0 read clear; evict_addr=0, forced=0. With MAX_PROBES=4 -> evict_addr=3, forced=1.
5. **Backpressure:** hold evict_ready=0 for 10 cycles -> evict_valid, evict_addr and evict_forced stable; req_ready=0; no bram_en pulses.
6. **Reset mid-scan:** assert rst during WAIT -> next cycle state IDLE, hand_pos=0, evict_valid=0, req_ready=1; a subsequent request behaves as in scenario 1.
